leitor_display: RTL and testbench

- Receive end of the 7-segment display path: samples a time-multiplexed, active-low segment/anode bus driven by the hex-to-segment decoder and digit scanner.
- Decodes each digit's segment pattern back to a 4-bit hex nibble and assembles a DIGITS-wide hex word.
- Flags illegal patterns and bus faults.
- Used on-chip as a self-check of the display path and as a bench monitor reading the display back as numbers.

---
 rtl/leitor_display.sv | 140 ++++++++++++++
 tb/tb_leitor_display.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/leitor_display.sv
// Readback monitor for a multiplexed, active-low 7-segment bus.
// Debounces each digit, decodes it back to hex and reports frame completion and faults.
module leitor_display #(
  parameter int DIGITS        = 8,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [6:0]            segmentos,
  input  logic [DIGITS-1:0]     anodos,
  output logic [4*DIGITS-1:0]   valor,
  output logic [DIGITS-1:0]     digito_ok,
  output logic                  quadro_valido,
  output logic                  quadro_fim,
  output logic                  erro
);

  localparam int BUS_W = DIGITS + 7;
  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  function automatic logic [CNT_W-1:0] inc_sat(input logic [CNT_W-1:0] c);
    return (c >= CNT_MAX) ? CNT_MAX : c + CNT_W'(1);
  endfunction

  // Argument is the lit-segment pattern (a..g, 1 = on); result is {legal, nibble}.
  function automatic logic [4:0] decode_seg(input logic [6:0] acesos);
    case (acesos)
      7'h7E:   return 5'h10;
      7'h30:   return 5'h11;
      7'h6D:   return 5'h12;
      7'h79:   return 5'h13;
      7'h33:   return 5'h14;
      7'h5B:   return 5'h15;
      7'h5F:   return 5'h16;
      7'h70:   return 5'h17;
      7'h7F:   return 5'h18;
      7'h73:   return 5'h19;
      7'h77:   return 5'h1A;
      7'h1F:   return 5'h1B;
      7'h4E:   return 5'h1C;
      7'h3D:   return 5'h1D;
      7'h4F:   return 5'h1E;
      7'h47:   return 5'h1F;
      default: return 5'h00;
    endcase
  endfunction

  logic [BUS_W-1:0]    barramento;
  logic [BUS_W-1:0]    amostra_p0;
  logic [CNT_W-1:0]    cont_p0;
  logic                capturado_p0;
  logic                mudou;
  logic                vld_p0;

  logic [DIGITS-1:0]   an_baixo;
  logic [6:0]          seg_acesos;
  logic [4:0]          decodificado;
  logic                legal;
  logic                branco;
  logic                ocioso;
  logic                multiplo;

  logic [DIGITS-1:0]   visto;
  logic [DIGITS-1:0]   visto_n;
  logic [4*DIGITS-1:0] valor_n;
  logic [DIGITS-1:0]   ok_n;
  logic                erro_n;
  logic                fim_n;
  logic                valido_n;

  assign barramento = {anodos, segmentos};
  assign mudou      = (barramento != amostra_p0);
  // One capture per stable period: the bus must still match on the edge the counter is saturated.
  assign vld_p0     = !mudou && (cont_p0 == CNT_MAX) && !capturado_p0;

  assign an_baixo     = ~amostra_p0[BUS_W-1:7];
  assign seg_acesos   = ~amostra_p0[6:0];
  assign decodificado = decode_seg(seg_acesos);
  assign legal        = decodificado[4];
  assign branco       = (seg_acesos == 7'h00);
  assign ocioso       = (an_baixo == '0);
  assign multiplo     = ((an_baixo & (an_baixo - DIGITS'(1))) != '0);

  // Stage p0 -> outputs: capture qualification, digit update and frame bookkeeping
  always_comb begin
    valor_n  = valor;
    ok_n     = digito_ok;
    visto_n  = visto;
    erro_n   = erro;
    fim_n    = 1'b0;
    valido_n = 1'b0;
    if (vld_p0 && !ocioso) begin
      if (multiplo) begin
        erro_n = 1'b1;
      end else begin
        for (int d = 0; d < DIGITS; d++) begin
          if (an_baixo[d]) begin
            ok_n[d] = legal;
            if (legal)
              valor_n[4*d +: 4] = decodificado[3:0];
          end
        end
        if (!legal && !branco)
          erro_n = 1'b1;
        visto_n = visto | an_baixo;
        if (&visto_n) begin
          fim_n    = 1'b1;
          valido_n = &ok_n;
          visto_n  = '0;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      amostra_p0    <= '1;
      cont_p0       <= '0;
      capturado_p0  <= 1'b0;
      visto         <= '0;
      valor         <= '0;
      digito_ok     <= '0;
      erro          <= 1'b0;
      quadro_fim    <= 1'b0;
      quadro_valido <= 1'b0;
    end else begin
      amostra_p0    <= barramento;
      cont_p0       <= mudou ? '0 : inc_sat(cont_p0);
      capturado_p0  <= !mudou && (capturado_p0 || vld_p0);
      visto         <= visto_n;
      valor         <= valor_n;
      digito_ok     <= ok_n;
      erro          <= erro_n;
      quadro_fim    <= fim_n;
      quadro_valido <= valido_n;
    end
  end

endmodule

// File: tb/tb_leitor_display.sv
// Randomized bench for leitor_display: a run-length based reference model predicts every output each cycle.
module tb_leitor_display;

  localparam int DIGITS = 8;
  localparam int STABLE = 4;

  logic                  clock = 1'b0;
  logic                  reset = 1'b1;
  logic [6:0]            segmentos = 7'h7F;
  logic [DIGITS-1:0]     anodos = '1;
  logic [4*DIGITS-1:0]   valor;
  logic [DIGITS-1:0]     digito_ok;
  logic                  quadro_valido;
  logic                  quadro_fim;
  logic                  erro;

  leitor_display #(.DIGITS(DIGITS), .STABLE_CYCLES(STABLE)) dut (
    .clock(clock), .reset(reset), .segmentos(segmentos), .anodos(anodos),
    .valor(valor), .digito_ok(digito_ok), .quadro_valido(quadro_valido),
    .quadro_fim(quadro_fim), .erro(erro)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Lit-segment patterns for hex 0..F
  logic [6:0] tabela [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                              7'h7F, 7'h73, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  // Reference model state
  logic [4*DIGITS-1:0] m_valor;
  logic [DIGITS-1:0]   m_ok;
  logic [DIGITS-1:0]   m_seen;
  logic                m_erro;
  logic                m_fim;
  logic                m_val;
  logic [DIGITS+6:0]   m_prev;
  int                  m_run;
  int                  n_fim;
  int                  n_val;

  // A value sampled on STABLE+1 consecutive edges is captured once, on the last of those edges.
  task automatic model_edge(input logic rst, input logic [DIGITS-1:0] an, input logic [6:0] sg);
    logic [DIGITS-1:0] low;
    logic [6:0] on;
    int d;
    int nib;
    m_fim = 1'b0;
    m_val = 1'b0;
    if (rst) begin
      m_valor = '0; m_ok = '0; m_seen = '0; m_erro = 1'b0;
      m_prev = '1; m_run = 1;
      return;
    end
    if ({an, sg} == m_prev) begin
      if (m_run < 1000) m_run++;
    end else begin
      m_prev = {an, sg};
      m_run = 1;
    end
    if (m_run != STABLE + 1) return;
    low = ~an;
    if ($countones(low) == 0) return;
    if ($countones(low) > 1) begin
      m_erro = 1'b1;
      return;
    end
    d = 0;
    for (int k = 0; k < DIGITS; k++) if (low[k]) d = k;
    on = ~sg;
    nib = -1;
    for (int k = 0; k < 16; k++) if (tabela[k] == on) nib = k;
    if (nib >= 0) begin
      m_valor[4*d +: 4] = 4'(nib);
      m_ok[d] = 1'b1;
    end else begin
      m_ok[d] = 1'b0;
      if (on != 7'h00) m_erro = 1'b1;
    end
    m_seen[d] = 1'b1;
    if (&m_seen) begin
      m_fim = 1'b1;
      m_val = &m_ok;
      m_seen = '0;
    end
  endtask

  task automatic step();
    @(posedge clock);
    model_edge(reset, anodos, segmentos);
    #1;
    check("valor", 64'(valor), 64'(m_valor));
    check("digito_ok", 64'(digito_ok), 64'(m_ok));
    check("erro", 64'(erro), 64'(m_erro));
    check("quadro_fim", 64'(quadro_fim), 64'(m_fim));
    check("quadro_valido", 64'(quadro_valido), 64'(m_val));
    if (quadro_fim === 1'b1) n_fim++;
    if (quadro_valido === 1'b1) n_val++;
  endtask

  task automatic show(input int d, input logic [6:0] raw, input int n);
    anodos = ~(DIGITS'(1) << d);
    segmentos = raw;
    repeat (n) step();
  endtask

  task automatic idle(input int n);
    anodos = '1;
    segmentos = 7'h7F;
    repeat (n) step();
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    idle(n);
    reset = 1'b0;
  endtask

  // Raw (active-low) bus value for a hex digit
  function automatic logic [6:0] raw_of(input int h);
    return ~tabela[h];
  endfunction

  initial begin
    do_reset(2);
    check("reset_valor", 64'(valor), 64'h0);
    check("reset_flags", 64'({digito_ok, erro, quadro_fim, quadro_valido}), 64'h0);

    // Too short to capture
    show(0, 7'b0000001, 3);
    idle(3);
    check("short_ok", 64'(digito_ok), 64'h0);
    check("short_valor", 64'(valor), 64'h0);

    // Legal frame 1..8
    n_fim = 0; n_val = 0;
    for (int d = 0; d < 8; d++) show(d, raw_of(d + 1), 6);
    idle(2);
    check("frame1_valor", 64'(valor), 64'h87654321);
    check("frame1_ok", 64'(digito_ok), 64'hFF);
    check("frame1_fim_count", 64'(n_fim), 64'd1);
    check("frame1_valido_count", 64'(n_val), 64'd1);

    // Frame with digit 3 blank
    n_fim = 0; n_val = 0;
    for (int d = 0; d < 8; d++) show(d, (d == 3) ? 7'h7F : raw_of(d + 1), 6);
    idle(2);
    check("blank_valor", 64'(valor), 64'h87654321);
    check("blank_ok", 64'(digito_ok), 64'hF7);
    check("blank_fim_count", 64'(n_fim), 64'd1);
    check("blank_valido_count", 64'(n_val), 64'd0);
    check("blank_erro", 64'(erro), 64'd0);

    // Two anodes low
    anodos = 8'hFC; segmentos = raw_of(5);
    repeat (6) step();
    idle(2);
    check("multi_erro", 64'(erro), 64'd1);
    check("multi_valor", 64'(valor), 64'h87654321);

    // Illegal pattern on digit 2, then a legal frame
    do_reset(1);
    n_fim = 0; n_val = 0;
    for (int d = 0; d < 8; d++) show(d, (d == 2) ? 7'b1010101 : raw_of(d), 6);
    check("illegal_erro", 64'(erro), 64'd1);
    check("illegal_ok2", 64'(digito_ok[2]), 64'd0);
    check("illegal_valido_count", 64'(n_val), 64'd0);
    for (int d = 0; d < 8; d++) show(d, raw_of(15 - d), 6);
    idle(2);
    check("after_valido_count", 64'(n_val), 64'd1);
    check("after_erro_sticky", 64'(erro), 64'd1);
    check("after_valor", 64'(valor), 64'h89ABCDEF);

    // Reset in the middle of a frame
    for (int d = 0; d < 5; d++) show(d, raw_of(d + 3), 6);
    do_reset(1);
    check("midreset_valor", 64'(valor), 64'h0);
    check("midreset_erro", 64'(erro), 64'd0);
    n_fim = 0; n_val = 0;
    for (int d = 0; d < 8; d++) show(d, raw_of(d), 6);
    idle(2);
    check("midreset_fim_count", 64'(n_fim), 64'd1);
    check("midreset_valor2", 64'(valor), 64'h76543210);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      int kind = $urandom_range(99);
      int hold = $urandom_range(8, 1);
      int sk = $urandom_range(99);
      if (kind < 2) begin
        do_reset(1);
        continue;
      end
      if (kind < 82)
        anodos = ~(DIGITS'(1) << $urandom_range(DIGITS - 1));
      else if (kind < 91)
        anodos = '1;
      else
        anodos = DIGITS'($urandom);
      if (sk < 80)
        segmentos = raw_of($urandom_range(15));
      else if (sk < 90)
        segmentos = 7'h7F;
      else
        segmentos = 7'($urandom);
      repeat (hold) step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
